// File: rtl/gs_latch_packer_if.sv
// gs_latch_packer_if: pixel stream in, grayscale latch word out
interface gs_latch_packer_if #(parameter int NUM_CHANNELS = 16);
  localparam int LATCH_SIZE = 48*NUM_CHANNELS+1;
  logic pix_valid;
  logic pix_ready;
  logic [23:0] pix_rgb;
  logic pix_last;
  logic lat_valid;
  logic lat_ready;
  logic [LATCH_SIZE-1:0] lat_data;
  logic err_sync;
  modport master(output pix_valid, pix_rgb, pix_last, lat_ready, input pix_ready, lat_valid, lat_data, err_sync);
  modport slave(input pix_valid, pix_rgb, pix_last, lat_ready, output pix_ready, lat_valid, lat_data, err_sync);
endinterface

// File: rtl/gs_latch_packer.sv
// gs_latch_packer: packs 16 RGB pixels into one grayscale latch word with a one-word output slot
module gs_latch_packer #(
  parameter int NUM_CHANNELS = 16,
  parameter int SCALE_SHIFT = 0
) (
  input logic TESTCLK,
  input logic nReset,
  gs_latch_packer_if.slave bus
);
  localparam int CW = $clog2(NUM_CHANNELS+1);
  localparam logic [CW-1:0] cnt_full = CW'(NUM_CHANNELS);
  localparam logic [CW-1:0] cnt_last = CW'(NUM_CHANNELS-1);
  logic [CW-1:0] cnt;
  logic [48*NUM_CHANNELS-1:0] asm_word;
  logic [47:0] px;
  logic accept, short_grp, long_grp, xfer;
  always_comb begin
    px = {({2{bus.pix_rgb[7:0]}} >> SCALE_SHIFT), ({2{bus.pix_rgb[15:8]}} >> SCALE_SHIFT), ({2{bus.pix_rgb[23:16]}} >> SCALE_SHIFT)};
    accept = bus.pix_valid && bus.pix_ready;
    short_grp = bus.pix_last && cnt != cnt_last;
    long_grp = !bus.pix_last && cnt == cnt_last;
    xfer = cnt == cnt_full && (!bus.lat_valid || bus.lat_ready);
  end
  assign bus.pix_ready = nReset && cnt != cnt_full;
  // accept and xfer never coincide: pix_ready is low whenever cnt is full
  always_ff @(posedge TESTCLK) begin
    if (!nReset) begin
      cnt <= '0;
      asm_word <= '0;
      bus.lat_valid <= 1'b0;
      bus.lat_data <= '0;
      bus.err_sync <= 1'b0;
    end else begin
      bus.err_sync <= accept && (short_grp || long_grp);
      if (xfer) begin
        bus.lat_data <= {1'b0, asm_word};
        bus.lat_valid <= 1'b1;
        cnt <= '0;
      end else begin
        if (bus.lat_valid && bus.lat_ready) bus.lat_valid <= 1'b0;
        if (accept) begin
          cnt <= short_grp ? '0 : cnt + 1'b1;
          if (!short_grp) asm_word[48*cnt +: 48] <= px;
        end
      end
    end
  end
endmodule

// File: tb/tb_gs_latch_packer.sv
// tb_gs_latch_packer: table-driven cycle vectors plus directed multi-cycle sequences
module tb_gs_latch_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  gs_latch_packer_if bus();
  gs_latch_packer_if bus2();
  gs_latch_packer u_dut(.TESTCLK(clk), .nReset(rst_n), .bus(bus));
  gs_latch_packer #(.SCALE_SHIFT(2)) u_scl(.TESTCLK(clk), .nReset(rst_n), .bus(bus2));
  typedef struct {
    logic rst_n, valid, last, rdy;
    logic [23:0] rgb;
    logic e_pr, e_lv, e_err, chk_d;
    logic [47:0] e_ch;
  } vec_t;
  vec_t vecs[$];
  int n_chk = 0;
  int n_bad = 0;
  function automatic logic [768:0] word(input logic [47:0] ch);
    return {1'b0, {16{ch}}};
  endfunction
  task automatic chk(input string name, input logic [768:0] act, input logic [768:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic r, input logic v, input logic l, input logic rd, input logic [23:0] rgb,
                     input logic pr, input logic lv, input logic er, input logic cd, input logic [47:0] ch);
    vec_t x;
    x.rst_n = r; x.valid = v; x.last = l; x.rdy = rd; x.rgb = rgb;
    x.e_pr = pr; x.e_lv = lv; x.e_err = er; x.chk_d = cd; x.e_ch = ch;
    vecs.push_back(x);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [23:0] rgb, input logic last);
    int t = 0;
    bus.pix_valid = 1'b1;
    bus.pix_rgb = rgb;
    bus.pix_last = last;
    while (!bus.pix_ready && t < 200) begin
      tick();
      t++;
    end
    if (t == 200) chk("send_timeout", bus.pix_ready, 1);
    tick();
    bus.pix_valid = 1'b0;
    bus.pix_last = 1'b0;
  endtask
  task automatic wait_lv(input string name);
    int t = 0;
    while (!bus.lat_valid && t < 100) begin
      tick();
      t++;
    end
    if (t == 100) chk(name, bus.lat_valid, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t;
    bus.pix_valid = 0; bus.pix_last = 0; bus.pix_rgb = 0; bus.lat_ready = 1;
    bus2.pix_valid = 0; bus2.pix_last = 0; bus2.pix_rgb = 0; bus2.lat_ready = 1;
    for (int i = 0; i < 2; i++) add(0, 1, 0, 1, 24'hABCDEF, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 1, i == 4, 1, 24'h123456, 1, 0, i == 4, 0, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 1, i == 15, 1, 24'h000A32, 1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 1, 0, 1, 48'h3232_0A0A_0000);
    add(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 1, 0, 1, 24'hFFFFFF, 1, 0, i == 15, 0, 0);
    add(1, 0, 0, 1, 0, 0, 1, 0, 1, 48'hFFFF_FFFF_FFFF);
    add(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;
      bus.pix_valid = vecs[i].valid;
      bus.pix_last = vecs[i].last;
      bus.pix_rgb = vecs[i].rgb;
      bus.lat_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_pix_ready", i), bus.pix_ready, vecs[i].e_pr);
      tick();
      chk($sformatf("v%0d_lat_valid", i), bus.lat_valid, vecs[i].e_lv);
      chk($sformatf("v%0d_err_sync", i), bus.err_sync, vecs[i].e_err);
      if (vecs[i].chk_d) chk($sformatf("v%0d_lat_data", i), bus.lat_data, word(vecs[i].e_ch));
    end
    bus.pix_valid = 0;
    bus.pix_last = 0;
    // distinct pixels: channel n gets {B,G,R} = {FFFF, 8080, {n,n}}
    for (int n = 0; n < 16; n++) send({8'(n), 8'h80, 8'hFF}, n == 15);
    wait_lv("dist_timeout");
    for (int n = 0; n < 16; n++)
      chk($sformatf("dist_ch%0d", n), bus.lat_data[48*n +: 48], {16'hFFFF, 16'h8080, {2{8'(n)}}});
    chk("dist_sel", bus.lat_data[768], 0);
    tick();
    chk("dist_drain", bus.lat_valid, 0);
    // backpressure: two groups queued behind a stalled shifter
    bus.lat_ready = 0;
    for (int i = 0; i < 16; i++) send(24'h111111, i == 15);
    for (int i = 0; i < 16; i++) send(24'h222222, i == 15);
    chk("bp_pix_ready", bus.pix_ready, 0);
    chk("bp_lat_valid", bus.lat_valid, 1);
    chk("bp_word1", bus.lat_data, word(48'h1111_1111_1111));
    repeat (3) tick();
    chk("bp_hold_pix_ready", bus.pix_ready, 0);
    chk("bp_hold_word1", bus.lat_data, word(48'h1111_1111_1111));
    bus.lat_ready = 1;
    tick();
    chk("bp_swap_lat_valid", bus.lat_valid, 1);
    chk("bp_word2", bus.lat_data, word(48'h2222_2222_2222));
    chk("bp_pix_ready_back", bus.pix_ready, 1);
    tick();
    chk("bp_drain", bus.lat_valid, 0);
    // reset mid-group with a word pending
    bus.lat_ready = 0;
    for (int i = 0; i < 16; i++) send(24'h333333, i == 15);
    for (int i = 0; i < 7; i++) send(24'h444444, 0);
    chk("rst_pending", bus.lat_valid, 1);
    rst_n = 0;
    tick();
    tick();
    chk("rst_lat_valid", bus.lat_valid, 0);
    chk("rst_lat_data", bus.lat_data, 0);
    chk("rst_pix_ready", bus.pix_ready, 0);
    chk("rst_err_sync", bus.err_sync, 0);
    rst_n = 1;
    bus.lat_ready = 1;
    #1;
    chk("rst_release_pix_ready", bus.pix_ready, 1);
    for (int i = 0; i < 16; i++) send(24'h0C0C0C, i == 15);
    wait_lv("rst_word_timeout");
    chk("rst_word", bus.lat_data, word(48'h0C0C_0C0C_0C0C));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rst_single_word_%0d", i), bus.lat_valid, 0);
    end
    // scale: SCALE_SHIFT=2 instance, FFFF >> 2 = 3FFF
    for (int i = 0; i < 16; i++) begin
      bus2.pix_valid = 1;
      bus2.pix_rgb = 24'hFFFFFF;
      bus2.pix_last = i == 15;
      tick();
    end
    bus2.pix_valid = 0;
    bus2.pix_last = 0;
    t = 0;
    while (!bus2.lat_valid && t < 100) begin
      tick();
      t++;
    end
    if (t == 100) chk("scale_timeout", bus2.lat_valid, 1);
    chk("scale_word", bus2.lat_data, word(48'h3FFF_3FFF_3FFF));
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
